// File: rtl/add8u_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : add8u_err_monitor
// Description : Streams (A, B, O) triples from an approximate adder, recomputes
//               A+B exactly and accumulates WCE, SAE, error count and sample
//               count over a programmed run. Optional squared-error sum is
//               enabled by defining ADD8U_ERRMON_MSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module add8u_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    input  logic [W:0]           in_o,
    output logic                 busy,
    output logic                 done,
    output logic [W:0]           wce,
    output logic [SUM_W-1:0]     sae,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [SUM_W+W:0]     sse
);

    localparam int c_EW    = W + 1;
    localparam int c_SA_W  = ((SUM_W > c_EW) ? SUM_W : c_EW) + 1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_done_nxt;
    logic               w_start_ok;
    logic               w_accept;
    logic [CNT_W-1:0]   w_acc_inc;

    logic               r_done;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic               r_s1_valid;
    logic [W:0]         r_err;
    logic [W:0]         r_wce;
    logic [SUM_W-1:0]   r_sae;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_sample_cnt;

    logic [W+1:0]       w_diff;
    logic [W:0]         w_err;
    logic [c_SA_W-1:0]  w_sae_sum;

    // Exact sum minus approximate result in W+2 bits; the MSB is the sign.
    assign w_diff = {2'b00, in_a} + {2'b00, in_b} - {1'b0, in_o};
    assign w_err  = w_diff[W+1] ? c_EW'(-w_diff) : w_diff[W:0];

    assign in_ready   = (r_state == S_RUN) && (r_acc_cnt < r_target);
    assign w_accept   = in_valid && in_ready;
    assign w_acc_inc  = r_acc_cnt + c_CNT_ONE;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_sae_sum  = c_SA_W'(r_sae) + c_SA_W'(r_err);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = (n_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && (w_acc_inc == r_target)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A zero-length restart from DONE must pulse done again.
        w_done_nxt = (w_state_nxt == S_DONE) && ((r_state != S_DONE) || w_start_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_target     <= '0;
            r_acc_cnt    <= '0;
            r_s1_valid   <= 1'b0;
            r_err        <= '0;
            r_wce        <= '0;
            r_sae        <= '0;
            r_err_cnt    <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_err <= w_err;
            end
            if (w_start_ok) begin
                r_target     <= n_samples;
                r_acc_cnt    <= '0;
                r_wce        <= '0;
                r_sae        <= '0;
                r_err_cnt    <= '0;
                r_sample_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_acc_cnt <= w_acc_inc;
                end
                if (r_s1_valid) begin
                    if (r_err > r_wce) begin
                        r_wce <= r_err;
                    end
                    if (|w_sae_sum[c_SA_W-1:SUM_W]) begin
                        r_sae <= '1;
                    end else begin
                        r_sae <= w_sae_sum[SUM_W-1:0];
                    end
                    if (r_err != '0) begin
                        r_err_cnt <= r_err_cnt + c_CNT_ONE;
                    end
                    r_sample_cnt <= r_sample_cnt + c_CNT_ONE;
                end
            end
        end
    end

`ifdef ADD8U_ERRMON_MSE_EN
    localparam int c_SSE_W = SUM_W + W + 1;
    localparam int c_SQ_W  = 2 * c_EW;
    localparam int c_SQA_W = ((c_SSE_W > c_SQ_W) ? c_SSE_W : c_SQ_W) + 1;

    logic [c_SSE_W-1:0] r_sse;
    logic [c_SQ_W-1:0]  w_sq;
    logic [c_SQA_W-1:0] w_sse_sum;

    assign w_sq      = c_SQ_W'(r_err) * c_SQ_W'(r_err);
    assign w_sse_sum = c_SQA_W'(r_sse) + c_SQA_W'(w_sq);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sse <= '0;
        end else if (w_start_ok) begin
            r_sse <= '0;
        end else if (r_s1_valid) begin
            if (|w_sse_sum[c_SQA_W-1:c_SSE_W]) begin
                r_sse <= '1;
            end else begin
                r_sse <= w_sse_sum[c_SSE_W-1:0];
            end
        end
    end

    assign sse = r_sse;
`else
    assign sse = '0;
`endif

    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = r_done;
    assign wce        = r_wce;
    assign sae        = r_sae;
    assign err_cnt    = r_err_cnt;
    assign sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_add8u_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_add8u_err_monitor
// Description : Directed self-checking bench for add8u_err_monitor, including
//               a SUM_W=4 instance for SAE saturation. Honours ADD8U_ERRMON_MSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add8u_err_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_samples = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [8:0]  in_o = '0;

    logic        in_ready, busy, done;
    logic [8:0]  wce;
    logic [23:0] sae;
    logic [15:0] err_cnt, sample_cnt;
    logic [32:0] sse;

    logic        in_ready4, busy4, done4;
    logic [8:0]  wce4;
    logic [3:0]  sae4;
    logic [15:0] err_cnt4, sample_cnt4;
    logic [12:0] sse4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add8u_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_o(in_o), .busy(busy), .done(done), .wce(wce), .sae(sae),
        .err_cnt(err_cnt), .sample_cnt(sample_cnt), .sse(sse)
    );

    // Shares all inputs with dut; only its SAE width differs.
    add8u_err_monitor #(.SUM_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
        .in_o(in_o), .busy(busy4), .done(done4), .wce(wce4), .sae(sae4),
        .err_cnt(err_cnt4), .sample_cnt(sample_cnt4), .sse(sse4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        n_samples = n;
        step();
        start = 1'b0;
    endtask

    // Present a triple and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int t;
        in_a = a; in_b = b; in_o = o; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Called right after the last accept edge: DRAIN, then one-cycle done.
    task automatic finish_run(input string tag);
        chk({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_drain_busy"},  {63'd0, busy},     64'd1);
        chk({tag, "_drain_done"},  {63'd0, done},     64'd0);
        step();
        chk({tag, "_done_hi"},     {63'd0, done},     64'd1);
        chk({tag, "_done_busy"},   {63'd0, busy},     64'd0);
        step();
        chk({tag, "_done_lo"},     {63'd0, done},     64'd0);
    endtask

    task automatic chk_stats(input string tag, input int e_wce, input int e_sae,
                             input int e_err, input int e_smp, input int e_sse);
        chk({tag, "_wce"}, 64'(wce), 64'(e_wce));
        chk({tag, "_sae"}, 64'(sae), 64'(e_sae));
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(e_smp));
        chk({tag, "_sse"}, 64'(sse), 64'(e_sse));
    endtask

    initial begin
        int exp_sse;
        step();
        step();
        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk_stats("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Exact results: no error
        do_start(16'd4);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        send(8'd3, 8'd5, 9'd8);
        send(8'd10, 8'd20, 9'd30);
        send(8'd255, 8'd255, 9'd510);
        send(8'd0, 8'd0, 9'd0);
        finish_run("t1");
        chk_stats("t1", 0, 0, 0, 4, 0);

        // Errors 8, 0, 8; stray start mid-run must be ignored
`ifdef ADD8U_ERRMON_MSE_EN
        exp_sse = 128;
`else
        exp_sse = 0;
`endif
        do_start(16'd3);
        send(8'd3, 8'd5, 9'd0);
        chk("t2_latency_smp", 64'(sample_cnt), 64'd0);
        step();
        chk("t2_latency_smp1", 64'(sample_cnt), 64'd1);
        chk("t2_latency_wce", 64'(wce), 64'd8);
        do_start(16'd7);
        chk("t2_start_ignored", {63'd0, busy}, 64'd1);
        send(8'd255, 8'd255, 9'd510);
        send(8'd0, 8'd0, 9'd8);
        finish_run("t2");
        chk_stats("t2", 8, 16, 2, 3, exp_sse);

        // Same triples with valid gaps; valid held high after target is ignored
        do_start(16'd3);
        chk_stats("t3_clear", 0, 0, 0, 0, 0);
        send(8'd3, 8'd5, 9'd0);
        step();
        send(8'd255, 8'd255, 9'd510);
        step();
        send(8'd0, 8'd0, 9'd8);
        in_valid = 1'b1;
        finish_run("t3");
        in_valid = 1'b0;
        chk_stats("t3", 8, 16, 2, 3, exp_sse);
        chk("t4sat_sae_gap", 64'(sae4), 64'd15);

        // Zero-length run
        do_start(16'd0);
        chk("t4_done", {63'd0, done}, 64'd1);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk_stats("t4", 0, 0, 0, 0, 0);
        step();
        chk("t4_done_lo", {63'd0, done}, 64'd0);
        chk("t4_busy_lo", {63'd0, busy}, 64'd0);

        // Errors 8, 8, 8: SAE saturates in the SUM_W=4 instance
        do_start(16'd3);
        send(8'd0, 8'd0, 9'd8);
        send(8'd4, 8'd4, 9'd0);
        send(8'd10, 8'd0, 9'd2);
        finish_run("t5");
        chk_stats("t5", 8, 24, 3, 3, exp_sse + exp_sse / 2);
        chk("t5_sat_sae", 64'(sae4), 64'd15);
        chk("t5_sat_wce", 64'(wce4), 64'd8);
        chk("t5_sat_err_cnt", 64'(err_cnt4), 64'd3);
        chk("t5_sat_done_seen", {63'd0, done4}, 64'd0);

        // Reset mid-run, then a clean run
        do_start(16'd4);
        send(8'd1, 8'd2, 9'd0);
        send(8'd9, 8'd9, 9'd20);
        step();
        chk("t6_pre_smp", 64'(sample_cnt), 64'd2);
        chk("t6_pre_wce", 64'(wce), 64'd3);
        rst = 1'b1;
        step();
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("t6_rst_done", {63'd0, done}, 64'd0);
        chk_stats("t6_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk("t6_no_done", {63'd0, done}, 64'd0);
        do_start(16'd1);
        send(8'd1, 8'd1, 9'd3);
        finish_run("t6");
`ifdef ADD8U_ERRMON_MSE_EN
        chk_stats("t6", 1, 1, 1, 1, 1);
`else
        chk_stats("t6", 1, 1, 1, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
